// File: rtl/ram_arbiter_if.sv
// Requester and RAM-pin bundle for ram_arbiter: two req/ack requesters on one side,
// the single-port RAM control pins on the other.
interface ram_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              req0;
    logic              op0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;
    logic              req1;
    logic              op1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;
    logic              ram_sel;
    logic              ram_op;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_inp;
    logic [DATA_W-1:0] ram_outp;
    logic              busy;

    modport slave (
        input  req0, op0, addr0, wdata0, req1, op1, addr1, wdata1, ram_outp,
        output ack0, rdata0, ack1, rdata1, ram_sel, ram_op, ram_addr, ram_inp, busy
    );

    modport master (
        output req0, op0, addr0, wdata0, req1, op1, addr1, wdata1, ram_outp,
        input  ack0, rdata0, ack1, rdata1, ram_sel, ram_op, ram_addr, ram_inp, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter sequencing accesses to an 8x8 single-port RAM.
// Every output is registered, so requests reach the RAM pins only through the FSM.
module ram_arbiter #(
    parameter int DATA_W        = 8,
    parameter int ADDR_W        = 3,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ptr_q, ptr_d;
    logic              win_q, win_d;
    logic              sel_q, sel_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] inp_q, inp_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              busy_q, busy_d;
    logic              grant1_s;

    // A lone requester always wins; on a tie the priority pointer decides.
    assign grant1_s = bus.req1 & (~bus.req0 | ptr_q);

    // Next-state and next-output logic for the IDLE -> ACCESS -> RELEASE sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        sel_d    = 1'b0;
        op_d     = op_q;
        addr_d   = addr_q;
        inp_d    = inp_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    win_d   = grant1_s;
                    sel_d   = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = ACCESS;
                    if (grant1_s) begin
                        op_d   = bus.op1;
                        addr_d = bus.addr1;
                        inp_d  = bus.wdata1;
                    end else begin
                        op_d   = bus.op0;
                        addr_d = bus.addr0;
                        inp_d  = bus.wdata0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = RELEASE;
                    sel_d   = 1'b0;
                    ack0_d  = ~win_q;
                    ack1_d  = win_q;
                    // ram_outp is only trusted here, while sel is still high.
                    if (!op_q && win_q) begin
                        rdata1_d = bus.ram_outp;
                    end else if (!op_q) begin
                        rdata0_d = bus.ram_outp;
                    end else begin
                        rdata0_d = rdata0_q;
                        rdata1_d = rdata1_q;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    sel_d = 1'b1;
                end
            end
            RELEASE: begin
                ptr_d   = ~win_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            ptr_q    <= 1'b0;
            win_q    <= 1'b0;
            sel_q    <= 1'b0;
            op_q     <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            inp_q    <= {DATA_W{1'b0}};
            rdata0_q <= {DATA_W{1'b0}};
            rdata1_q <= {DATA_W{1'b0}};
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            sel_q    <= sel_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            inp_q    <= inp_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.ram_sel  = sel_q;
    assign bus.ram_op   = op_q;
    assign bus.ram_addr = addr_q;
    assign bus.ram_inp  = inp_q;
    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one DUT with ACCESS_CYCLES=1 and one with 3,
// each wired to a behavioural 8x8 single-port RAM with a tri-state read bus.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    ram_arbiter_if #(.DATA_W(8), .ADDR_W(3)) bus1();
    ram_arbiter_if #(.DATA_W(8), .ADDR_W(3)) bus3();

    ram_arbiter #(.DATA_W(8), .ADDR_W(3), .ACCESS_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );
    ram_arbiter #(.DATA_W(8), .ADDR_W(3), .ACCESS_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
    );

    logic [7:0] mem1 [8];
    logic [7:0] mem3 [8];

    always @(posedge clk) begin
        if (bus1.ram_sel && bus1.ram_op) mem1[bus1.ram_addr] <= bus1.ram_inp;
        if (bus3.ram_sel && bus3.ram_op) mem3[bus3.ram_addr] <= bus3.ram_inp;
    end
    assign bus1.ram_outp = bus1.ram_sel ? mem1[bus1.ram_addr] : 8'hzz;
    assign bus3.ram_outp = bus3.ram_sel ? mem3[bus3.ram_addr] : 8'hzz;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one request on bus1; lat = cycles from req sampled to ack, selc = sel-high cycles.
    task automatic run_b1(input bit who, input bit op, input logic [2:0] a, input logic [7:0] d,
                          output int lat, output int selc);
        lat  = -1;
        selc = 0;
        if (who) begin
            bus1.req1 = 1'b1; bus1.op1 = op; bus1.addr1 = a; bus1.wdata1 = d;
        end else begin
            bus1.req0 = 1'b1; bus1.op0 = op; bus1.addr0 = a; bus1.wdata0 = d;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus1.ram_sel === 1'b1) selc++;
            if ((who ? bus1.ack1 : bus1.ack0) === 1'b1) begin
                lat = i;
                break;
            end
        end
        @(posedge clk); #1;
        if (who) bus1.req1 = 1'b0;
        else     bus1.req0 = 1'b0;
    endtask

    task automatic run_b3(input bit op, input logic [2:0] a, input logic [7:0] d,
                          output int lat, output int selc);
        lat  = -1;
        selc = 0;
        bus3.req1 = 1'b1; bus3.op1 = op; bus3.addr1 = a; bus3.wdata1 = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus3.ram_sel === 1'b1) selc++;
            if (bus3.ack1 === 1'b1) begin
                lat = i;
                break;
            end
        end
        @(posedge clk); #1;
        bus3.req1 = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus1.req0 = 1'b1; bus1.op0 = 1'b1; bus1.addr0 = 3'd0; bus1.wdata0 = 8'h11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (bus1.ram_sel !== 1'b0) $display("FAIL rst_sel: got %b want 0", bus1.ram_sel); else pass_cnt++;
        total_cnt++; if (bus1.ack0 !== 1'b0) $display("FAIL rst_ack0: got %b want 0", bus1.ack0); else pass_cnt++;
        total_cnt++; if (bus1.rdata0 !== 8'h00) $display("FAIL rst_rdata0: got %h want 00", bus1.rdata0); else pass_cnt++;
        total_cnt++; if (bus1.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus1.busy); else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total_cnt++; if (bus1.ram_sel !== 1'b1) $display("FAIL rst_grant_sel: got %b want 1", bus1.ram_sel); else pass_cnt++;
        total_cnt++; if ({bus1.ram_op, bus1.ram_addr, bus1.ram_inp} !== {1'b1, 3'd0, 8'h11})
            $display("FAIL rst_grant_fields: got op=%b addr=%0d inp=%h want op=1 addr=0 inp=11",
                     bus1.ram_op, bus1.ram_addr, bus1.ram_inp);
        else pass_cnt++;
        total_cnt++; if (bus1.busy !== 1'b1) $display("FAIL rst_grant_busy: got %b want 1", bus1.busy); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if ({bus1.ack0, bus1.ram_sel} !== 2'b10)
            $display("FAIL rst_grant_ack: got ack0=%b sel=%b want ack0=1 sel=0", bus1.ack0, bus1.ram_sel);
        else pass_cnt++;
        @(posedge clk); #1;
        bus1.req0 = 1'b0;
        @(negedge clk);
        total_cnt++; if ({bus1.ack0, bus1.busy} !== 2'b00)
            $display("FAIL rst_after_ack: got ack0=%b busy=%b want 0 0", bus1.ack0, bus1.busy);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int lat, selc;
        run_b1(1'b0, 1'b1, 3'd7, 8'h99, lat, selc);
        bus1.req1 = 1'b1; bus1.op1 = 1'b0; bus1.addr1 = 3'd7; bus1.wdata1 = 8'h00;
        @(posedge clk); #2;
        total_cnt++; if (bus1.ram_sel !== 1'b1) $display("FAIL abort_pre_sel: got %b want 1", bus1.ram_sel); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if ({bus1.ram_sel, bus1.busy, bus1.ack1} !== 3'b000)
            $display("FAIL abort_sel_drop: got sel=%b busy=%b ack1=%b want 0 0 0", bus1.ram_sel, bus1.busy, bus1.ack1);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++; if ({bus1.ack1, bus1.rdata1} !== {1'b0, 8'h00})
            $display("FAIL abort_no_ack: got ack1=%b rdata1=%h want 0 00", bus1.ack1, bus1.rdata1);
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_b1(1'b1, 1'b0, 3'd7, 8'h00, lat, selc);
        total_cnt++; if (lat !== 2) $display("FAIL abort_retry_lat: got %0d want 2", lat); else pass_cnt++;
        total_cnt++; if (bus1.rdata1 !== 8'h99) $display("FAIL abort_retry_rdata1: got %h want 99", bus1.rdata1); else pass_cnt++;
    endtask

    task automatic test_single();
        int lat, selc;
        run_b1(1'b0, 1'b1, 3'd1, 8'hAA, lat, selc);
        total_cnt++; if ({lat, selc} !== {32'd2, 32'd1})
            $display("FAIL single_wr_timing: got lat=%0d sel_cycles=%0d want 2 1", lat, selc);
        else pass_cnt++;
        total_cnt++; if (bus1.rdata0 !== 8'h00) $display("FAIL single_wr_rdata0: got %h want 00", bus1.rdata0); else pass_cnt++;
        total_cnt++; if ({bus1.ram_op, bus1.ram_addr, bus1.ram_inp} !== {1'b1, 3'd1, 8'hAA})
            $display("FAIL single_wr_hold: got op=%b addr=%0d inp=%h want 1 1 AA", bus1.ram_op, bus1.ram_addr, bus1.ram_inp);
        else pass_cnt++;
        run_b1(1'b0, 1'b0, 3'd1, 8'h00, lat, selc);
        total_cnt++; if (lat !== 2) $display("FAIL single_rd_lat: got %0d want 2", lat); else pass_cnt++;
        total_cnt++; if (bus1.rdata0 !== 8'hAA) $display("FAIL single_rd_rdata0: got %h want AA", bus1.rdata0); else pass_cnt++;
    endtask

    task automatic test_contention();
        int  lat, selc, n;
        int  ord [4];
        bit  a0, a1;
        do_reset();
        n = 0;
        for (int k = 0; k < 4; k++) ord[k] = -1;
        bus1.req0 = 1'b1; bus1.op0 = 1'b1; bus1.addr0 = 3'd2; bus1.wdata0 = 8'hCC;
        bus1.req1 = 1'b1; bus1.op1 = 1'b1; bus1.addr1 = 3'd3; bus1.wdata1 = 8'hF0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a0 = (bus1.ack0 === 1'b1);
            a1 = (bus1.ack1 === 1'b1);
            if (a0 && n < 4) begin ord[n] = 0; n++; end
            if (a1 && n < 4) begin ord[n] = 1; n++; end
            @(posedge clk); #1;
            if (a0) bus1.req0 = 1'b0;
            if (a1) bus1.req1 = 1'b0;
            if (n >= 2) break;
        end
        bus1.req0 = 1'b0;
        bus1.req1 = 1'b0;
        total_cnt++; if ({n, ord[0], ord[1]} !== {32'd2, 32'd0, 32'd1})
            $display("FAIL contention_order: got n=%0d first=%0d second=%0d want 2 0 1", n, ord[0], ord[1]);
        else pass_cnt++;
        run_b1(1'b0, 1'b0, 3'd2, 8'h00, lat, selc);
        total_cnt++; if (bus1.rdata0 !== 8'hCC) $display("FAIL contention_rd2: got %h want CC", bus1.rdata0); else pass_cnt++;
        run_b1(1'b1, 1'b0, 3'd3, 8'h00, lat, selc);
        total_cnt++; if (bus1.rdata1 !== 8'hF0) $display("FAIL contention_rd3: got %h want F0", bus1.rdata1); else pass_cnt++;
    endtask

    task automatic test_fairness();
        int       lat, selc, n, nrise, last_rise, gap_bad, rd_bad;
        bit [5:0] ord_bits;
        bit       prev_sel;
        do_reset();
        run_b1(1'b0, 1'b1, 3'd4, 8'h44, lat, selc);
        run_b1(1'b1, 1'b1, 3'd5, 8'h5A, lat, selc);
        n = 0; nrise = 0; last_rise = -1; gap_bad = 0; rd_bad = 0; ord_bits = 6'b000000; prev_sel = 1'b0;
        bus1.req0 = 1'b1; bus1.op0 = 1'b0; bus1.addr0 = 3'd4; bus1.wdata0 = 8'h00;
        bus1.req1 = 1'b1; bus1.op1 = 1'b0; bus1.addr1 = 3'd5; bus1.wdata1 = 8'h00;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus1.ram_sel === 1'b1 && !prev_sel) begin
                if (last_rise >= 0 && (i - last_rise) != 3) gap_bad++;
                last_rise = i;
                nrise++;
            end
            prev_sel = (bus1.ram_sel === 1'b1);
            if (bus1.ack0 === 1'b1 && n < 6) begin
                if (bus1.rdata0 !== 8'h44) rd_bad++;
                n++;
            end
            if (bus1.ack1 === 1'b1 && n < 6) begin
                if (bus1.rdata1 !== 8'h5A) rd_bad++;
                ord_bits[n] = 1'b1;
                n++;
            end
            if (n >= 6) break;
        end
        @(posedge clk); #1;
        bus1.req0 = 1'b0;
        bus1.req1 = 1'b0;
        total_cnt++; if ({n, ord_bits} !== {32'd6, 6'b101010})
            $display("FAIL fair_order: got n=%0d order_bits=%b want 6 101010", n, ord_bits);
        else pass_cnt++;
        total_cnt++; if ({nrise, gap_bad} !== {32'd6, 32'd0})
            $display("FAIL fair_windows: got windows=%0d bad_gaps=%0d want 6 0", nrise, gap_bad);
        else pass_cnt++;
        total_cnt++; if (rd_bad !== 0) $display("FAIL fair_rdata: got %0d bad reads want 0", rd_bad); else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        total_cnt++; if ({bus1.ram_sel, bus1.busy} !== 2'b00)
            $display("FAIL fair_idle_after: got sel=%b busy=%b want 0 0", bus1.ram_sel, bus1.busy);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_access3();
        int lat, selc;
        run_b3(1'b1, 3'd6, 8'h55, lat, selc);
        total_cnt++; if ({lat, selc} !== {32'd4, 32'd3})
            $display("FAIL ac3_wr_timing: got lat=%0d sel_cycles=%0d want 4 3", lat, selc);
        else pass_cnt++;
        total_cnt++; if (bus3.rdata1 !== 8'h00) $display("FAIL ac3_wr_rdata1: got %h want 00", bus3.rdata1); else pass_cnt++;
        run_b3(1'b0, 3'd6, 8'h00, lat, selc);
        total_cnt++; if ({lat, selc} !== {32'd4, 32'd3})
            $display("FAIL ac3_rd_timing: got lat=%0d sel_cycles=%0d want 4 3", lat, selc);
        else pass_cnt++;
        total_cnt++; if (bus3.rdata1 !== 8'h55) $display("FAIL ac3_rd_rdata1: got %h want 55", bus3.rdata1); else pass_cnt++;
    endtask

    initial begin
        bus1.req0 = 1'b0; bus1.op0 = 1'b0; bus1.addr0 = 3'd0; bus1.wdata0 = 8'h00;
        bus1.req1 = 1'b0; bus1.op1 = 1'b0; bus1.addr1 = 3'd0; bus1.wdata1 = 8'h00;
        bus3.req0 = 1'b0; bus3.op0 = 1'b0; bus3.addr0 = 3'd0; bus3.wdata0 = 8'h00;
        bus3.req1 = 1'b0; bus3.op1 = 1'b0; bus3.addr1 = 3'd0; bus3.wdata1 = 8'h00;
        test_reset();
        test_reset_abort();
        test_single();
        test_contention();
        test_fairness();
        test_access3();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
